// File: rtl/exc_unit_pkg.sv
// Shared exception-unit definitions: ExcCode values, CP0 register numbers
// and the per-stage exception tag record.
package exc_unit_pkg;

    localparam logic [4:0] EXC_INT  = 5'd0;
    localparam logic [4:0] EXC_ADEL = 5'd4;
    localparam logic [4:0] EXC_ADES = 5'd5;
    localparam logic [4:0] EXC_SYS  = 5'd8;
    localparam logic [4:0] EXC_BP   = 5'd9;
    localparam logic [4:0] EXC_RI   = 5'd10;
    localparam logic [4:0] EXC_OV   = 5'd12;

    localparam logic [4:0] CP0_BADVADDR = 5'd8;
    localparam logic [4:0] CP0_STATUS   = 5'd12;
    localparam logic [4:0] CP0_CAUSE    = 5'd13;
    localparam logic [4:0] CP0_EPC      = 5'd14;

    localparam logic [31:0] STATUS_RST = 32'h0040_0000;

    typedef struct packed {
        logic        v;
        logic [4:0]  code;
        logic        bd;
        logic [31:0] pc;
        logic [31:0] badva;
    } exc_tag_t;

    function automatic logic is_addr_exc(input logic [4:0] code);
        return (code == EXC_ADEL) || (code == EXC_ADES);
    endfunction

endpackage

// File: rtl/exc_unit_sync.sv
// Two-flop synchroniser for the asynchronous interrupt request lines.
module exc_sync #(
    parameter int W = 6
) (
    input  logic         clk,
    input  logic         resetn,
    input  logic [W-1:0] i_async,
    output logic [W-1:0] o_sync
);

    logic [W-1:0] r_s1;
    logic [W-1:0] r_s2;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_s1 <= '0;
            r_s2 <= '0;
        end else begin
            r_s1 <= i_async;
            r_s2 <= r_s1;
        end
    end

    assign o_sync = r_s2;

endmodule

// File: rtl/exc_unit.sv
// Precise exception / interrupt unit: carries per-stage exception tags to
// commit, takes exceptions and ERET there, and owns the CP0 exception regs.
module exc_unit
    import exc_unit_pkg::*;
#(
    parameter int          NSTAGE  = 5,
    parameter int          NINT    = 6,
    parameter logic [31:0] EXC_VEC = 32'hBFC00380
) (
    input  logic                clk,
    input  logic                resetn,
    input  logic [NINT-1:0]     ext_int,
    input  logic                adv,
    input  logic [NSTAGE-1:0]   stg_valid,
    input  logic [NSTAGE-1:0]   raise,
    input  logic [5*NSTAGE-1:0] raise_code,
    input  logic [32*NSTAGE-1:0] stg_pc,
    input  logic [32*NSTAGE-1:0] stg_badva,
    input  logic [NSTAGE-1:0]   stg_bd,
    input  logic                eret,
    input  logic                cp0_we,
    input  logic [4:0]          cp0_addr,
    input  logic [31:0]         cp0_wdata,
    output logic [31:0]         cp0_rdata,
    output logic                flush,
    output logic [31:0]         redirect_pc,
    output logic [31:0]         epc,
    output logic [31:0]         cause,
    output logic [31:0]         status,
    output logic [31:0]         badvaddr
);

    localparam int C = NSTAGE - 1;

    exc_tag_t    r_tag [NSTAGE-1:1];
    exc_tag_t    w_rtag [NSTAGE];
    exc_tag_t    w_prev [NSTAGE-1:1];
    exc_tag_t    w_ctag;
    logic [NINT-1:0] w_sync;
    logic [5:0]  w_hwip;
    logic        w_adv, w_exc, w_int, w_take, w_eret, w_tbd;
    logic [4:0]  w_code;
    logic [31:0] w_tpc;

    logic [31:0] r_epc, r_bva, r_status;
    logic        r_bd;
    logic [1:0]  r_ip_sw;
    logic [5:0]  r_ip_hw;
    logic [4:0]  r_code;

    exc_sync #(.W(NINT)) u_sync (
        .clk     (clk),
        .resetn  (resetn),
        .i_async (ext_int),
        .o_sync  (w_sync)
    );

    for (genvar k = 0; k < 6; k++) begin : g_hwip
        if (k < NINT) begin : g_on
            assign w_hwip[k] = w_sync[k];
        end else begin : g_off
            assign w_hwip[k] = 1'b0;
        end
    end

    // Gating with resetn keeps flush/redirect quiet for the whole reset window.
    assign w_adv = adv & resetn;

    // A raise from a bubble stage carries no instruction and is dropped.
    always_comb begin
        for (int i = 0; i < NSTAGE; i++) begin
            w_rtag[i] = '0;
            if (raise[i] && stg_valid[i])
                w_rtag[i] = '{v: 1'b1, code: raise_code[5*i +: 5], bd: stg_bd[i],
                              pc: stg_pc[32*i +: 32], badva: stg_badva[32*i +: 32]};
        end
    end

    // Older (already tagged) exceptions beat anything raised later in the stage.
    always_comb begin
        w_prev[1] = w_rtag[0];
        for (int i = 2; i < NSTAGE; i++)
            w_prev[i] = r_tag[i-1].v ? r_tag[i-1] : w_rtag[i-1];
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int i = 1; i < NSTAGE; i++) r_tag[i] <= '0;
        end else if (w_adv) begin
            for (int i = 1; i < NSTAGE; i++) r_tag[i] <= flush ? '0 : w_prev[i];
        end
    end

    assign w_ctag = r_tag[C].v ? r_tag[C] : w_rtag[C];
    assign w_exc  = stg_valid[C] & w_ctag.v;
    assign w_int  = stg_valid[C] & r_status[0] & ~r_status[1] &
                    (|({r_ip_hw, r_ip_sw} & r_status[15:8]));
    assign w_take = w_adv & (w_int | w_exc);
    assign w_eret = w_adv & eret & ~w_take;
    assign w_code = w_int ? EXC_INT : w_ctag.code;
    assign w_tbd  = w_int ? stg_bd[C] : w_ctag.bd;
    assign w_tpc  = w_int ? stg_pc[32*C +: 32] : w_ctag.pc;

    assign flush       = w_take | w_eret;
    assign redirect_pc = w_take ? EXC_VEC : (w_eret ? r_epc : 32'd0);

    // MTC0 is applied first so the take fields below override it on the same edge.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_epc    <= '0;
            r_bva    <= '0;
            r_status <= STATUS_RST;
            r_bd     <= 1'b0;
            r_ip_sw  <= '0;
            r_ip_hw  <= '0;
            r_code   <= '0;
        end else begin
            r_ip_hw <= w_hwip;
            if (w_adv) begin
                if (cp0_we) begin
                    case (cp0_addr)
                        CP0_BADVADDR: r_bva    <= cp0_wdata;
                        CP0_STATUS:   r_status <= cp0_wdata;
                        CP0_CAUSE:    r_ip_sw  <= cp0_wdata[9:8];
                        CP0_EPC:      r_epc    <= cp0_wdata;
                        default: ;
                    endcase
                end
                if (w_take) begin
                    r_status[1] <= 1'b1;
                    r_code      <= w_code;
                    r_bd        <= w_tbd;
                    if (!r_status[1]) r_epc <= w_tbd ? w_tpc - 32'd4 : w_tpc;
                    if (is_addr_exc(w_code)) r_bva <= w_ctag.badva;
                end else if (w_eret) begin
                    r_status[1] <= 1'b0;
                end
            end
        end
    end

    assign epc      = r_epc;
    assign badvaddr = r_bva;
    assign status   = r_status;
    assign cause    = {r_bd, 15'd0, r_ip_hw, r_ip_sw, 1'b0, r_code, 2'b00};

    always_comb begin
        cp0_rdata = '0;
        case (cp0_addr)
            CP0_BADVADDR: cp0_rdata = r_bva;
            CP0_STATUS:   cp0_rdata = r_status;
            CP0_CAUSE:    cp0_rdata = cause;
            CP0_EPC:      cp0_rdata = r_epc;
            default:      cp0_rdata = '0;
        endcase
    end

endmodule

// File: tb/tb_exc_unit.sv
// Scoreboard bench for exc_unit: stimulus queues expected flush events,
// a negedge monitor pops and checks them against the DUT.
module tb_exc_unit;
    import exc_unit_pkg::*;

    localparam int          NS  = 5;
    localparam int          NI  = 6;
    localparam logic [31:0] VEC = 32'hBFC00380;

    logic             clk, resetn, adv, eret, cp0_we, flush;
    logic [NI-1:0]    ext_int;
    logic [NS-1:0]    stg_valid, raise, stg_bd;
    logic [5*NS-1:0]  raise_code;
    logic [32*NS-1:0] stg_pc, stg_badva;
    logic [4:0]       cp0_addr;
    logic [31:0]      cp0_wdata, cp0_rdata, redirect_pc, epc, cause, status, badvaddr;

    exc_unit #(.NSTAGE(NS), .NINT(NI), .EXC_VEC(VEC)) dut (
        .clk(clk), .resetn(resetn), .ext_int(ext_int), .adv(adv),
        .stg_valid(stg_valid), .raise(raise), .raise_code(raise_code),
        .stg_pc(stg_pc), .stg_badva(stg_badva), .stg_bd(stg_bd), .eret(eret),
        .cp0_we(cp0_we), .cp0_addr(cp0_addr), .cp0_wdata(cp0_wdata),
        .cp0_rdata(cp0_rdata), .flush(flush), .redirect_pc(redirect_pc),
        .epc(epc), .cause(cause), .status(status), .badvaddr(badvaddr)
    );

    typedef struct {
        logic [31:0] cyc;
        logic [31:0] rpc;
        logic [31:0] epc;
        logic [4:0]  code;
        logic        bd;
        logic        exl;
        logic [31:0] bva;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] cyc = 0;
    int          n_tests = 0;
    int          n_fail  = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
        n_tests++;
        if (act !== want) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, want, cyc);
        end
    endtask

    task automatic step(input int n = 1);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic set_stage(input int s, input logic r, input logic [4:0] code,
                             input logic bd, input logic [31:0] pc, input logic [31:0] bva);
        raise[s]             = r;
        raise_code[5*s +: 5] = code;
        stg_bd[s]            = bd;
        stg_pc[32*s +: 32]   = pc;
        stg_badva[32*s +: 32] = bva;
    endtask

    task automatic expect_flush(input int lat, input logic [31:0] rpc, input logic [31:0] e_epc,
                                input logic [4:0] code, input logic bd, input logic exl,
                                input logic [31:0] bva);
        exp_t e;
        e.cyc = cyc + lat; e.rpc = rpc; e.epc = e_epc;
        e.code = code; e.bd = bd; e.exl = exl; e.bva = bva;
        exp_q.push_back(e);
    endtask

    task automatic mtc0(input logic [4:0] a, input logic [31:0] d);
        cp0_we = 1'b1; cp0_addr = a; cp0_wdata = d;
        step();
        cp0_we = 1'b0;
    endtask

    // Monitor: each flush is matched to the oldest expectation; the CP0
    // effects are checked one cycle later, after the committing edge.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (resetn === 1'b1 && flush === 1'b1) begin
                if (exp_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_flush: redirect_pc %h at cycle %0d, none expected",
                             redirect_pc, cyc);
                end else begin
                    e = exp_q.pop_front();
                    chk("flush_cycle", cyc, e.cyc);
                    chk("redirect_pc", redirect_pc, e.rpc);
                    @(negedge clk);
                    chk("epc", epc, e.epc);
                    chk("exccode", {27'd0, cause[6:2]}, {27'd0, e.code});
                    chk("cause_bd", {31'd0, cause[31]}, {31'd0, e.bd});
                    chk("status_exl", {31'd0, status[1]}, {31'd0, e.exl});
                    chk("badvaddr", badvaddr, e.bva);
                end
            end
        end
    end

    initial begin
        resetn = 1'b0; adv = 1'b1; eret = 1'b0; cp0_we = 1'b0; cp0_addr = '0;
        cp0_wdata = '0; ext_int = '0; stg_valid = '1; raise = '0; stg_bd = '0;
        raise_code = '0; stg_pc = '0; stg_badva = '0;
        step(3);
        chk("rst_flush", {31'd0, flush}, 32'd0);
        chk("rst_redirect", redirect_pc, 32'd0);
        chk("rst_epc", epc, 32'd0);
        chk("rst_cause", cause, 32'd0);
        chk("rst_status", status, 32'h0040_0000);
        chk("rst_badvaddr", badvaddr, 32'd0);
        resetn = 1'b1;
        step(2);

        // Ov raised in stage 2 reaches commit two cycles later
        set_stage(2, 1, EXC_OV, 0, 32'h8000_0010, 32'd0);
        expect_flush(2, VEC, 32'h8000_0010, EXC_OV, 0, 1, 32'd0);
        step();
        set_stage(2, 0, 0, 0, 32'd0, 32'd0);
        step(4);

        // MFC0 reads and MTC0 EPC, then ERET back to it
        cp0_addr = CP0_EPC;
        #1 chk("mfc0_epc", cp0_rdata, 32'h8000_0010);
        cp0_addr = 5'd3;
        #1 chk("mfc0_undef", cp0_rdata, 32'd0);
        mtc0(CP0_EPC, 32'h8000_1000);
        eret = 1'b1;
        expect_flush(0, 32'h8000_1000, 32'h8000_1000, EXC_OV, 0, 0, 32'd0);
        step();
        eret = 1'b0;
        step(3);

        // Older RI tag beats a later AdEL on the same instruction
        set_stage(1, 1, EXC_RI, 0, 32'h8000_0200, 32'd0);
        expect_flush(3, VEC, 32'h8000_0200, EXC_RI, 0, 1, 32'd0);
        step();
        set_stage(1, 0, 0, 0, 32'd0, 32'd0);
        step();
        set_stage(3, 1, EXC_ADEL, 0, 32'h8000_0200, 32'h0000_DEAD);
        step();
        set_stage(3, 0, 0, 0, 32'd0, 32'd0);
        step(3);
        eret = 1'b1;
        expect_flush(0, 32'h8000_0200, 32'h8000_0200, EXC_RI, 0, 0, 32'd0);
        step();
        eret = 1'b0;
        step(3);

        // AdEL at commit in a delay slot
        set_stage(4, 1, EXC_ADEL, 1, 32'h8000_0104, 32'h0000_1003);
        expect_flush(0, VEC, 32'h8000_0100, EXC_ADEL, 1, 1, 32'h0000_1003);
        step();
        set_stage(4, 0, 0, 0, 32'd0, 32'd0);
        step(3);
        eret = 1'b1;
        expect_flush(0, 32'h8000_0100, 32'h8000_0100, EXC_ADEL, 1, 0, 32'h0000_1003);
        step();
        eret = 1'b0;
        step(3);

        // ERET together with a commit raise: the exception wins
        set_stage(4, 1, EXC_ADES, 0, 32'h8000_0300, 32'h0000_2222);
        eret = 1'b1;
        expect_flush(0, VEC, 32'h8000_0300, EXC_ADES, 0, 1, 32'h0000_2222);
        step();
        set_stage(4, 0, 0, 0, 32'd0, 32'd0);
        eret = 1'b0;
        step(3);
        eret = 1'b1;
        expect_flush(0, 32'h8000_0300, 32'h8000_0300, EXC_ADES, 0, 0, 32'h0000_2222);
        step();
        eret = 1'b0;
        step(3);

        // Interrupt masked by EXL=1: no take
        mtc0(CP0_STATUS, 32'h0040_0403);
        ext_int = 6'b000001;
        step(6);
        chk("ip_hw_seen", cause & 32'h0000_FC00, 32'h0000_0400);
        chk("exl_masks_int", status, 32'h0040_0403);
        ext_int = '0;
        step(5);
        chk("ip_hw_clear", cause & 32'h0000_FC00, 32'd0);

        // Interrupt taken three cycles after the request
        set_stage(4, 0, 0, 0, 32'h8000_0400, 32'd0);
        mtc0(CP0_STATUS, 32'h0040_0401);
        ext_int = 6'b000001;
        expect_flush(3, VEC, 32'h8000_0400, EXC_INT, 0, 1, 32'h0000_2222);
        step(6);
        ext_int = '0;
        step(3);

        // Async reset while stalled with a live tag, and with a commit raise pending
        set_stage(1, 1, EXC_OV, 0, 32'h8000_0500, 32'd0);
        step();
        set_stage(1, 0, 0, 0, 32'd0, 32'd0);
        adv = 1'b0;
        step(2);
        #2 resetn = 1'b0;
        #1;
        chk("rst2_flush", {31'd0, flush}, 32'd0);
        chk("rst2_redirect", redirect_pc, 32'd0);
        chk("rst2_epc", epc, 32'd0);
        chk("rst2_cause", cause, 32'd0);
        chk("rst2_status", status, 32'h0040_0000);
        chk("rst2_badvaddr", badvaddr, 32'd0);
        adv = 1'b1;
        set_stage(4, 1, EXC_SYS, 0, 32'h8000_0600, 32'd0);
        #1;
        chk("rst_flush_gated", {31'd0, flush}, 32'd0);
        chk("rst_redirect_gated", redirect_pc, 32'd0);
        set_stage(4, 0, 0, 0, 32'd0, 32'd0);
        step(2);
        resetn = 1'b1;
        step(8);
        chk("post_rst_status", status, 32'h0040_0000);

        chk("scoreboard_drained", exp_q.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/exc_unit.md
EXC_UNIT -- requirements
Module: exc_unit

Interface
REQ-001 Parameter NSTAGE, default 5: pipeline stages tracked; stage NSTAGE-1 is the commit stage.
REQ-002 Parameter NINT, default 6: hardware interrupt lines.
REQ-003 Parameter EXC_VEC, default 32'hBFC00380: exception entry address.
REQ-004 clk  in  1  sole clock, rising edge.
REQ-005 resetn  in  1  asynchronous, active-low reset.
REQ-006 ext_int  in  NINT  level interrupt requests, asynchronous to clk.
REQ-007 adv  in  1  pipeline advances this cycle (0 = stall).
REQ-008 stg_valid  in  NSTAGE  stage holds a live instruction.
REQ-009 raise  in  NSTAGE  exception detected in stage i this cycle.
REQ-010 raise_code  in  5*NSTAGE  ExcCode per stage.
REQ-011 stg_pc, stg_badva  in  32*NSTAGE  PC and faulting address per stage.
REQ-012 stg_bd  in  NSTAGE  stage instruction sits in a delay slot.
REQ-013 eret  in  1  ERET at commit stage.
REQ-014 cp0_we, cp0_addr, cp0_wdata  in  1/5/32  MTC0 at commit; cp0_rdata out 32 MFC0 read data.
REQ-015 flush  out  1  kill all stages; redirect_pc  out  32  fetch target when flush=1.
REQ-016 epc, cause, status, badvaddr  out  32 each  architectural CP0 views.

Function
REQ-017 Per-stage tag register tag[i] = {v, code, bd, pc, badva}, i = 1..NSTAGE-1; on adv, tag[i] <= tag[i-1] if tag[i-1].v, else raise[i-1] data, else cleared.
REQ-018 Older exception precedence: an existing tag is never overwritten by a later raise in that stage.
REQ-019 Commit exception pending = stg_valid[NSTAGE-1] & (tag[NSTAGE-1].v | raise[NSTAGE-1]), tag winning.
REQ-020 ext_int synchronised through two flops; Cause.IP[7:2] = synced ext_int each cycle, IP[1:0] software-writable.
REQ-021 Interrupt pending = Status.IE & ~Status.EXL & |(Cause.IP & Status.IM); taken at commit of next valid instruction, code 0, priority above all synchronous exceptions.
REQ-022 Take (exception or interrupt) only when adv=1; same cycle: flush=1, redirect_pc=EXC_VEC, EXL<=1, Cause.ExcCode<=code, Cause.BD<=bd, EPC<=bd ? pc-4 : pc (EPC unchanged if EXL already 1).
REQ-023 BadVAddr updated only for codes 4 (AdEL) and 5 (AdES).
REQ-024 ERET with adv=1 and no take: flush=1, redirect_pc=EPC, EXL<=0.
REQ-025 Take and ERET same cycle: take wins; ERET ignored.
REQ-026 MTC0 to regs 8/12/13/14 applied when adv=1; on simultaneous take, take fields (EXL, ExcCode, BD, EPC, BadVAddr) win.
REQ-027 flush clears every tag[i].v on the same edge.
REQ-028 cp0_rdata combinational by cp0_addr; undefined addresses read 0.
REQ-029 adv=0: tags, CP0 state (except IP[7:2]) and sync flops' outputs-to-IP hold; flush=0.

Reset
REQ-030 resetn low: all tags cleared, flush=0, redirect_pc=0, EPC=0, BadVAddr=0, Cause=0, Status=32'h0040_0000 (BEV=1), sync flops 0.
REQ-031 Reset mid-flush aborts it; first post-reset cycle flush=0.

Structure
REQ-032 Shared package holds ExcCode constants (Int, AdEL, AdES, Sys, Bp, RI, Ov), CP0 register numbers and the tag record type.
REQ-033 One sub-module exc_sync (NINT-wide two-flop synchroniser).

Verification
REQ-034 raise[2]=1 code 12 (Ov), pc 0x80000010, bd=0, adv held 1 -> two cycles later flush=1, redirect_pc=0xBFC00380, EPC=0x80000010, ExcCode=12, EXL=1.
REQ-035 raise[1] code 10 and later raise[3] code 4 on same instruction -> ExcCode=10, BadVAddr unchanged.
REQ-036 AdEL at commit, bd=1, pc 0x80000104, badva 0x1003 -> EPC=0x80000100, BD=1, BadVAddr=0x1003.
REQ-037 IE=1, IM[2]=1, ext_int[0]=1 -> ExcCode=0 taken 3 cycles later at commit, EXL=1; with EXL=1 initially -> no take.
REQ-038 eret with EPC=0x80001000 -> flush, redirect_pc=0x80001000, EXL=0; eret plus commit raise same cycle -> exception taken.
REQ-039 resetn low while adv=0 with tags valid -> all outputs reach REQ-030 values immediately.
